// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline register with a two-entry skid buffer and synchronous flush.
// Defining PIPE_STAGE_STATS_EN adds a saturating stall_cycles counter port.
module pipe_stage_buf #(
  parameter int DATA_W = 71,
  parameter logic [DATA_W-1:0] RST_DATA = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef PIPE_STAGE_STATS_EN
  output logic [15:0]       stall_cycles,
`endif
  output logic [DATA_W-1:0] out_data
);
  logic              main_valid;
  logic [DATA_W-1:0] skid;
  logic              push;
  logic              pop;
  assign push      = in_valid && in_ready;
  assign pop       = main_valid && out_ready;
  assign out_valid = main_valid;
  // in_ready is itself the flop holding "skid empty", so it never depends on out_ready combinationally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      in_ready   <= 1'b1;
      out_data   <= RST_DATA;
      skid       <= RST_DATA;
    end else begin
      main_valid <= !flush && (push || !in_ready || (main_valid && !pop));
      in_ready   <= flush || (in_ready ? !(push && main_valid && !pop) : pop);
      if (!flush && ((push && (!main_valid || pop)) || (!in_ready && pop)))
        out_data <= in_ready ? in_data : skid;
      if (!flush && push && main_valid && !pop)
        skid <= in_data;
    end
  end
`ifdef PIPE_STAGE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cycles <= 16'h0;
    else if (main_valid && !out_ready && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'h1;
  end
`endif
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: directed stimulus against a queue-based occupancy model plus literal spot checks.
module tb_pipe_stage_buf;
  localparam int W = 71;
  localparam logic [W-1:0] RST = 71'h12_3456_789A_BCDE_F012;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready;
  logic out_valid;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] out_data;
  logic [15:0] stall_cycles;
  logic [W-1:0] q[$];
  logic [15:0] exp_sc;
  logic pu, po;
  logic chk_en = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [W-1:0] a, b, c;
  logic [15:0] pv = 16'b1011_0111_1100_1101;
  logic [12:0] pr = 13'b1_0110_1110_0101;

  pipe_stage_buf #(.DATA_W(W), .RST_DATA(RST)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
`ifdef PIPE_STAGE_STATS_EN
    .stall_cycles(stall_cycles),
`endif
    .out_data(out_data)
  );

`ifndef PIPE_STAGE_STATS_EN
  assign stall_cycles = 16'h0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      exp_sc = 16'h0;
    end else begin
      pu = in_valid && q.size() < 2;
      po = q.size() > 0 && out_ready;
      if (q.size() > 0 && !out_ready && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'h1;
      if (flush) q.delete();
      else begin
        if (po) void'(q.pop_front());
        if (pu) q.push_back(in_data);
      end
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model out_valid", W'(out_valid), W'(q.size() > 0));
      chk("model in_ready", W'(in_ready), W'(q.size() < 2));
      if (q.size() > 0) chk("model out_data", out_data, q[0]);
`ifdef PIPE_STAGE_STATS_EN
      chk("model stall_cycles", W'(stall_cycles), W'(exp_sc));
`endif
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] pl(input int i);
    return W'({32'hDEADBEEF, 32'(i)});
  endfunction

  initial begin
    a = 71'h0A_AAAA_0000_1111_2222;
    b = 71'h0B_BBBB_3333_4444_5555;
    c = 71'h0C_CCCC_6666_7777_8888;
    step;
    step;
    chk("reset out_data", out_data, RST);
    chk("reset out_valid", W'(out_valid), W'(0));
    chk("reset in_ready", W'(in_ready), W'(1));
    reset = 1'b0;
    chk_en = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data = pl(i);
      step;
      chk("stream out_data", out_data, pl(i));
      chk("stream out_valid", W'(out_valid), W'(1));
      chk("stream in_ready", W'(in_ready), W'(1));
    end
    in_valid = 1'b0;
    step;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = a;
    step;
    in_data = b;
    step;
    chk("bp in_ready low", W'(in_ready), W'(0));
    chk("bp head A", out_data, a);
    in_data = c;
    step;
    chk("bp hold A", out_data, a);
    chk("bp still full", W'(in_ready), W'(0));
    out_ready = 1'b1;
    step;
    chk("release head B", out_data, b);
    chk("release in_ready", W'(in_ready), W'(1));
    step;
    chk("release head C", out_data, c);
    in_valid = 1'b0;
    step;
    chk("release drained", W'(out_valid), W'(0));
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = a;
    step;
    in_data = b;
    step;
    in_valid = 1'b0;
    flush = 1'b1;
    out_ready = 1'b1;
    step;
    flush = 1'b0;
    chk("flush full out_valid", W'(out_valid), W'(0));
    chk("flush full in_ready", W'(in_ready), W'(1));
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = a;
    step;
    in_data = c;
    flush = 1'b1;
    step;
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush drops push", W'(out_valid), W'(0));
    for (int i = 0; i < 48; i++) begin
      in_valid = pv[i % 16];
      out_ready = pr[i % 13];
      in_data = W'(i + 100);
      flush = (i == 30);
      step;
    end
    flush = 1'b0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = a;
    step;
    in_data = b;
    step;
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async rst out_valid", W'(out_valid), W'(0));
    chk("async rst in_ready", W'(in_ready), W'(1));
    chk("async rst out_data", out_data, RST);
    step;
    reset = 1'b0;
    step;
`ifdef PIPE_STAGE_STATS_EN
    chk("stats cleared", W'(stall_cycles), W'(0));
    in_valid = 1'b1;
    in_data = a;
    step;
    in_valid = 1'b0;
    for (int i = 0; i < 70000; i++) step;
    chk("stats saturated", W'(stall_cycles), W'(16'hFFFF));
    step;
    chk("stats stays", W'(stall_cycles), W'(16'hFFFF));
`endif
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
